// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and 16x oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    // Tick-counter values at which the line is sampled: mid start bit, then once per bit time.
    localparam logic [TICK_W-1:0] MID_SAMPLE  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_SAMPLE = TICK_W'(15);

endpackage

// File: rtl/uart_sync.sv
// Two-stage synchronizer for the asynchronous serial line; resets to 1 so an idle line shows no edge.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-edge detect, mid-bit sampling, optional parity, framing check.
// Handshake: o_valid is a one-clk strobe with no back-pressure; o_data/o_frame_err/o_parity_err hold until the next strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy,
    output rx_state_t            o_state
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       ODD_BIT  = (PARITY_ODD != 0);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state;
    rx_state_t            next_state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_q;

    logic edge_fall;
    logic mid_hit;
    logic last_hit;
    logic shift_en;
    logic par_sample;
    logic stop_sample;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_prev <= 1'b1;
        else     rx_prev <= rx_s;
    end

    assign edge_fall = rx_prev & ~rx_s;
    assign mid_hit   = rx_tick && (tick_cnt == MID_SAMPLE);
    assign last_hit  = rx_tick && (tick_cnt == LAST_SAMPLE);

    always_comb begin
        next_state  = state;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                // Only a high-to-low transition starts a frame; a line stuck low (break) is ignored.
                if (edge_fall) next_state = START;
            end
            START: begin
                if (mid_hit) next_state = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (last_hit) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_hit) begin
                    par_sample = 1'b1;
                    next_state = STOP;
                end
            end
            STOP: begin
                if (last_hit) begin
                    stop_sample = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_err_q <= 1'b0;
        end else begin
            state <= next_state;
            // Counter is parked at zero in IDLE so stray ticks there are harmless.
            if (next_state != state || state == IDLE) tick_cnt <= '0;
            else if (rx_tick)                         tick_cnt <= tick_cnt + 1'b1;
            if (next_state != state) bit_cnt <= '0;
            else if (shift_en)       bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (par_sample) par_err_q <= (^shift_reg) ^ rx_s ^ ODD_BIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_valid <= stop_sample;
            if (stop_sample) begin
                o_data       <= shift_reg;
                o_frame_err  <= ~rx_s;
                o_parity_err <= (PARITY_EN != 0) && par_err_q;
            end
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three configurations (8N1, 8E1, 7O1) driven by a serial-line model, checked every cycle.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       rx_tick;
    logic [2:0] rx_line;

    logic [7:0] od [3];
    logic [6:0] d2;
    logic [2:0] ov, ofe, ope, ob;
    rx_state_t  st [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcount [3];
    int vt_last [3];
    int vt_prev [3];

    // Entry: {dut[1:0], parity_err, frame_err, data[7:0]}
    logic [11:0] exp_q[$];

    assign od[2] = {1'b0, d2};

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .i_rx(rx_line[0]),
        .o_data(od[0]), .o_valid(ov[0]), .o_frame_err(ofe[0]), .o_parity_err(ope[0]),
        .o_busy(ob[0]), .o_state(st[0]));

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .i_rx(rx_line[1]),
        .o_data(od[1]), .o_valid(ov[1]), .o_frame_err(ofe[1]), .o_parity_err(ope[1]),
        .o_busy(ob[1]), .o_state(st[1]));

    uart_rx #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .rx_tick(rx_tick), .i_rx(rx_line[2]),
        .o_data(d2), .o_valid(ov[2]), .o_frame_err(ofe[2]), .o_parity_err(ope[2]),
        .o_busy(ob[2]), .o_state(st[2]));

    // ---------------- clock / tick ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_tick = 1'b1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    initial begin
        #(900000 * 10);
        errors++;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst(input int n);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (n) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drive_bit(input int k, input logic v);
        rx_line[k] = v;
        wait_clks(BIT_CLKS);
    endtask

    // Line model: start, LSB-first data, optional parity, stop; then idle-high gap if gap > 0.
    task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                              input logic sbit, input int gap);
        int         nb;
        logic       pe;
        logic       po;
        logic [7:0] dm;
        logic       perr;
        nb   = (k == 2) ? 7 : 8;
        pe   = (k != 0);
        po   = (k == 2);
        dm   = (k == 2) ? {1'b0, d[6:0]} : d;
        perr = pe && ((($countones(dm) + int'(pbit)) % 2) != int'(po));
        exp_q.push_back({2'(k), perr, ~sbit, dm});
        drive_bit(k, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(k, dm[i]);
        if (pe) drive_bit(k, pbit);
        drive_bit(k, sbit);
        if (gap > 0) begin
            rx_line[k] = 1'b1;
            wait_clks(gap);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard / compare ----------------
    logic [9:0]  hold [3];
    logic [2:0]  prev_v;
    logic [11:0] e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                chk("reset_outputs", {od[k], ope[k], ofe[k], ov[k], ob[k]}, 0);
                chk("reset_state", st[k], IDLE);
                hold[k] = '0;
            end
            prev_v = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid dut=%0d data=%0h required=no_pulse cyc=%0d", k, od[k], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("valid_dut", k, e[11:10]);
                        chk("frame_fields", {ope[k], ofe[k], od[k]}, e[9:0]);
                        hold[k] = e[9:0];
                    end
                    vcount[k]++;
                    vt_prev[k] = vt_last[k];
                    vt_last[k] = cyc;
                end else begin
                    chk("held_fields", {ope[k], ofe[k], od[k]}, hold[k]);
                end
                if (prev_v[k]) chk("busy_after_valid", ob[k], 0);
                prev_v[k] = ov[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    int v_before;

    initial begin
        for (int k = 0; k < 3; k++) begin
            vcount[k]  = 0;
            vt_last[k] = 0;
            vt_prev[k] = 0;
            hold[k]    = '0;
        end
        prev_v  = '0;
        rx_line = 3'b111;
        rst     = 1'b1;
        wait_clks(6);
        #2 rst = 1'b0;
        wait_clks(10);

        // Basic 0x55 frame
        send_frame(0, 8'h55, 1'b0, 1'b1, 20);
        drain();
        chk("lit_55_data", od[0], 32'h55);
        chk("lit_55_ferr", ofe[0], 0);
        chk("lit_55_busy", ob[0], 0);
        chk("lit_55_count", vcount[0], 1);

        // Start glitch: low for 3 ticks then high
        v_before = vcount[0];
        rx_line[0] = 1'b0;
        wait_clks(8);
        chk("lit_glitch_busy", ob[0], 1);
        wait_clks(4);
        rx_line[0] = 1'b1;
        wait_clks(BIT_CLKS);
        chk("lit_glitch_idle", ob[0], 0);
        chk("lit_glitch_novalid", vcount[0], v_before);
        chk("lit_glitch_data", od[0], 32'h55);

        // Framing error followed by a break, then a good frame
        send_frame(0, 8'hA3, 1'b0, 1'b0, 0);
        wait_clks(3 * BIT_CLKS);
        chk("lit_break_idle", ob[0], 0);
        rx_line[0] = 1'b1;
        wait_clks(BIT_CLKS);
        chk("lit_a3_data", od[0], 32'hA3);
        chk("lit_a3_ferr", ofe[0], 1);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 20);
        drain();
        chk("lit_3c_data", od[0], 32'h3C);
        chk("lit_3c_ferr", ofe[0], 0);

        // Even parity on 0x07
        send_frame(1, 8'h07, 1'b1, 1'b1, 20);
        drain();
        chk("lit_par_good", ope[1], 0);
        send_frame(1, 8'h07, 1'b0, 1'b1, 20);
        drain();
        chk("lit_par_bad", ope[1], 1);
        chk("lit_par_data", od[1], 32'h07);

        // Reset during data bit 4
        v_before = vcount[0];
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        wait_clks(BIT_CLKS / 2);
        pulse_rst(3);
        wait_clks(2 * BIT_CLKS);
        chk("lit_rst_novalid", vcount[0], v_before);
        chk("lit_rst_data", od[0], 0);
        chk("lit_rst_busy", ob[0], 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 20);
        drain();
        chk("lit_rst_3c", od[0], 32'h3C);

        // Back-to-back 0x00 then 0xFF
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 20);
        drain();
        chk("lit_b2b_spacing", vt_last[0] - vt_prev[0], 640);
        chk("lit_b2b_data", od[0], 32'hFF);
        chk("lit_b2b_err", {ofe[0], ope[0]}, 0);

        // Randomized frames on every configuration
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 12; n++) begin
                logic [7:0] d;
                logic       sb;
                logic       pb;
                int         gap;
                d   = 8'($urandom_range(0, 255));
                sb  = ($urandom_range(0, 4) != 0);
                pb  = 1'($urandom_range(0, 1));
                gap = $urandom_range(0, 3) * 30;
                if (!sb && gap < 8) gap = 8;
                send_frame(k, d, pb, sb, gap);
            end
            rx_line[k] = 1'b1;
            wait_clks(20);
            drain();
        end

        wait_clks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
